latch_tx_serializer: RTL
========================

# latch_tx_serializer

Byte serializer between the debug unit and the UART transmitter. On a request it snapshots a wide word, such as a pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB) or a register value. It then streams the snapshot to `uart_tx` one byte at a time, least-significant byte first, using the transmitter's start/done handshake. Optionally it appends the ASCII `'R'` ready terminator that the host waits on.

## Interface
- `MAX_BITS`, 136, width of the snapshot input (17 bytes; covers the 129-bit ID/EX latch zero-extended)
- `N`, 8, UART byte width
- `i_clk`  in  1  system clock, all logic on rising edge
- `i_rst`  in  1  reset, asynchronous, active-high
- `i_start`  in  1  request pulse; sampled only in IDLE
- `i_data`  in  MAX_BITS  word to send; captured on accepted `i_start`
- `i_num_bytes`  in  5  payload byte count; captured with `i_data`
- `i_tx_done`  in  1  one-cycle pulse from `uart_tx`, byte fully shifted out
- `o_tx_start`  out  1  one-cycle pulse to `uart_tx`, launch `o_tx_data`
- `o_tx_data`  out  N  byte to transmit
- `o_busy`  out  1  high from the cycle after accept until `o_done`
- `o_done`  out  1  one-cycle pulse, transfer complete

## Operation
- States: IDLE, LOAD, WAIT, TERM (only with macro), DONE.
- IDLE:
  - `i_start`=1 captures `i_data` into the shift register and `i_num_bytes` into the byte counter.
  - A count above MAX_BITS/8 is clamped to MAX_BITS/8.
  - Next state is LOAD, or TERM/DONE if the count is 0.
- LOAD:
  - Drives `o_tx_data` = shift[7:0] and pulses `o_tx_start` for one cycle.
  - Goes to WAIT.
- WAIT:
  - `o_tx_data` is held stable.
  - On `i_tx_done`: shift right 8 bits, decrement the counter.
  - If the counter becomes 0, go to TERM (macro) or DONE; otherwise go to LOAD.
- TERM:
  - Drives `o_tx_data`=8'h52 and pulses `o_tx_start` once.
  - Waits for `i_tx_done`, then goes to DONE.
- DONE: pulses `o_done` for one cycle, then returns to IDLE.
- Byte order: byte 0 = `i_data[7:0]`, byte k = `i_data[8k+7:8k]`.
- `i_start` while not in IDLE is ignored and has no effect on the current snapshot.
- `i_tx_done` outside WAIT/TERM-wait is ignored.
- `i_data` changing after accept has no effect, so a snapshot taken in continuous mode is coherent.

## Timing
- Reset values: state IDLE, `o_tx_start`=0, `o_tx_data`=8'h00, `o_busy`=0, `o_done`=0, shift register and counter 0.
- Accept at edge 0 (IDLE, `i_start`=1). `o_tx_start` and byte 0 are valid during cycle 1, and `o_busy`=1 from cycle 1.
- `i_tx_done` seen at edge k → next `o_tx_start` valid in cycle k+1 (one cycle gap per byte, excluding UART time).
- After the final `i_tx_done` at edge k: `o_done`=1 in cycle k+1, `o_busy`=0 and IDLE in cycle k+2. A new `i_start` is accepted at edge k+2.
- Zero-length request without the macro: `o_done` in cycle 1, no `o_tx_start`.
- Reset asserted mid-transfer:
  - Immediate return to IDLE.
  - No `o_done` and no further `o_tx_start`.
  - A byte already in flight in `uart_tx` is not the block's concern.
- Total cycles per transfer = sum of UART byte times + (bytes + terminator) + 2.

## Configuration
- `LATCH_TX_READY_EN`
  - Defined: after the payload, one extra byte 8'h52 (`'R'`) is sent before `o_done`. A zero-length request sends only `'R'`.
  - Undefined: the TERM state and terminator logic are compiled out. Exactly `i_num_bytes` bytes are sent; a zero-length request completes with no UART traffic.

## Test plan
- Macro on, `i_num_bytes`=4, `i_data`=32'h3C01_0001, `i_tx_done` 20 cycles after each start → `o_tx_data` sequence 01,00,01,3C,52; 5 `o_tx_start` pulses; one `o_done`.
- `i_num_bytes`=17, `i_data`[135:0] with byte k = k → bytes 00..10 in order; `i_data` changed mid-transfer does not alter the output.
- `i_num_bytes`=31 → clamped; exactly 17 payload bytes sent.
- `i_start` pulsed during WAIT with different data → ignored; the original stream completes unchanged.
- Macro off, `i_num_bytes`=0 → `o_done` in cycle 1, no `o_tx_start`. Macro on, same input → single byte 8'h52.
- `i_rst` asserted while in WAIT after byte 2 of 9 → outputs return to reset values next evaluation; no `o_done`. A fresh 9-byte request afterwards completes normally.

Source files
------------

// File: rtl/latch_tx_serializer.sv
// latch_tx_serializer: snapshots a wide word on request and streams it to
// uart_tx one byte at a time, least-significant byte first, using the
// transmitter's start/done handshake.
// Optional feature macro: LATCH_TX_READY_EN appends an ASCII 'R' (8'h52)
// terminator after the payload, before o_done.
module latch_tx_serializer #(
  parameter int unsigned MAX_BITS = 136,
  parameter int unsigned N        = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [MAX_BITS-1:0] i_data,
  input  logic [4:0]          i_num_bytes,
  input  logic                i_tx_done,
  output logic                o_tx_start,
  output logic [N-1:0]        o_tx_data,
  output logic                o_busy,
  output logic                o_done
);

  localparam logic [4:0] MAX_BYTES = 5'(MAX_BITS / 8);

`ifdef LATCH_TX_READY_EN
  localparam logic [N-1:0] TERM_BYTE = N'(8'h52);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
`ifdef LATCH_TX_READY_EN
    S_TERM,
    S_TWAIT,
`endif
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [MAX_BITS-1:0] shift_q;
  logic [4:0]          cnt_q;
  logic [4:0]          req_cnt;

  // Requested byte count, clamped to the snapshot width.
  always_comb begin
    req_cnt = (i_num_bytes > MAX_BYTES) ? MAX_BYTES : i_num_bytes;
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Snapshot shift register and remaining-byte counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (state_q == S_IDLE && i_start) begin
      shift_q <= i_data;
      cnt_q   <= req_cnt;
    end else if (state_q == S_WAIT && i_tx_done) begin
      shift_q <= shift_q >> N;
      cnt_q   <= cnt_q - 5'd1;
    end
  end

  // Next-state logic and Moore outputs.
  always_comb begin
    state_d    = state_q;
    o_tx_start = 1'b0;
    o_tx_data  = shift_q[N-1:0];
    o_busy     = (state_q != S_IDLE);
    o_done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (req_cnt == '0) begin
`ifdef LATCH_TX_READY_EN
            state_d = S_TERM;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        o_tx_start = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (i_tx_done) begin
          if (cnt_q == 5'd1) begin
`ifdef LATCH_TX_READY_EN
            state_d = S_TERM;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_LOAD;
          end
        end
      end
`ifdef LATCH_TX_READY_EN
      S_TERM: begin
        o_tx_start = 1'b1;
        o_tx_data  = TERM_BYTE;
        state_d    = S_TWAIT;
      end
      S_TWAIT: begin
        o_tx_data = TERM_BYTE;
        if (i_tx_done) begin
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
